score4_game_ctrl: RTL and testbench
===================================

Name: score4_game_ctrl

Overview:
- Game-sequencing controller for the score4 (connect-four) display path.
- Owns the board state and drives the renderer's `panel`, `play` and `turn` inputs.
- Turns three player buttons into cursor moves and piece drops. A drop scans a column bottom-up, one row per cycle, and commits the piece into the lowest empty cell.
- Tracks the move count and stops the game when the board is full.

Parameters:
- ROWS, 6, board rows; row 0 = bottom, row ROWS-1 = top.
- COLS, 7, board columns; column COLS-1 = leftmost, column 0 = rightmost.
- CURSOR_INIT, 6, column index of the cursor after reset (leftmost).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_left  in  1  level, already synchronised; rising edge moves the cursor left.
- btn_right  in  1  level, already synchronised; rising edge moves the cursor right.
- btn_drop  in  1  level, already synchronised; rising edge drops a piece in the cursor column.
- panel  out  [1:0] x [ROWS-1:0][COLS-1:0] unpacked  cell state: 00 empty, 01 red, 10 green; 11 never driven.
- play  out  COLS  one-hot cursor column.
- turn  out  1  0 = red to move, 1 = green to move.
- busy  out  1  high while in SCAN or COMMIT.
- col_full  out  1  one-cycle pulse: a drop was rejected because the column is full.
- game_over  out  1  board full; sticky until reset.

Behaviour:
- Reset (rst=0, async):
  - all panel cells = 00; play = 1<<CURSOR_INIT; turn = 0.
  - busy = 0, col_full = 0, game_over = 0.
  - move_cnt = 0; edge-detect history registers = 0; state = IDLE.
  - Reset is effective mid-operation: any scan in progress is aborted and no write occurs.
- Edge detection:
  - per button, edge = btn & ~btn_q; btn_q is updated every cycle in every state.
  - Edges arriving outside IDLE are discarded, not queued.
- IDLE:
  - Drop edge has priority. Latch col = index of the set bit in play, r = 0, go to SCAN. Move edges in the same cycle are ignored.
  - Else, left edge without right edge: play <<= 1. At bit COLS-1 the cursor saturates (no change).
  - Else, right edge without left edge: play >>= 1. At bit 0 the cursor saturates.
  - Left and right edges in the same cycle: no change.
- SCAN (one row per cycle):
  - If panel[r][col]==00: write panel[r][col] = turn ? 10 : 01, go to COMMIT.
  - Else if r==ROWS-1: pulse col_full for 1 cycle, go to IDLE. panel and turn are unchanged.
  - Else: r <= r+1.
  - r is $clog2(ROWS) bits wide and never exceeds ROWS-1.
- COMMIT:
  - turn <= ~turn; move_cnt <= move_cnt+1. move_cnt is $clog2(ROWS*COLS+1) bits wide.
  - If move_cnt+1 == ROWS*COLS: game_over <= 1, go to OVER. Else go to IDLE.
- OVER:
  - All buttons ignored; outputs frozen.
  - Only reset exits this state.
- Latency, with the drop edge sampled in cycle N and the empty cell at row r:
  - busy high from N+1.
  - panel write visible at N+2+r.
  - turn toggle visible at N+3+r.
  - busy low and IDLE again at N+3+r.
- Full-column latency: col_full visible at N+1+ROWS; IDLE again at N+1+ROWS.
- Cursor moves are visible 1 cycle after the edge.
- play is always exactly one-hot.
- panel only changes in SCAN and is glitch-free. The renderer may sample it at any time.

Optional Feature:
- WRAP_CURSOR_EN defined:
  - left at bit COLS-1 wraps to bit 0; right at bit 0 wraps to bit COLS-1.
  - every other cursor behaviour is unchanged.
- Not defined: the cursor saturates at both edges, as in IDLE above.

Test Plan:
1. Reset, then 3 right edges then 1 left edge -> play 1000000, 0100000, 0010000, 0001000, then 0010000; turn=0 throughout.
2. Cursor at col 6, drop -> panel[0][6]=01 at N+2; turn=1 at N+3. Second drop -> panel[1][6]=10, turn=0, busy high for 2 and 3 cycles respectively.
3. Fill col 3 with 6 drops, then a 7th drop -> col_full pulses 1 cycle at N+7; panel and turn unchanged; move_cnt=6.
4. During a SCAN of col 4, toggle btn_left and btn_drop -> both ignored; play unchanged after return to IDLE.
5. Fill all 42 cells, then press btns -> game_over=1 after the 42nd COMMIT; no further panel, play or turn change. Assert rst -> all cleared.
6. Assert rst low at SCAN r=2 of a drop -> panel stays all 00, state IDLE. WRAP_CURSOR_EN build: left at play=1000000 -> 0000001.

Source files
------------

// File: rtl/score4_game_ctrl.sv
// ---------------------------------------------------------------------------
// score4_game_ctrl
// Game-sequencing controller for the score4 (connect-four) display path.
// Owns the board, turns three synchronised buttons into cursor moves and
// piece drops, and stops the game once every cell is occupied.
//
// A drop scans the cursor column bottom-up, one row per cycle, and writes
// the moving player's colour into the lowest empty cell.
//
// Configuration macro:
//   WRAP_CURSOR_EN  - when defined, the cursor wraps from the leftmost
//                     column to the rightmost (and back) instead of
//                     saturating at the board edges.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   btn_left   in   level; rising edge moves the cursor one column left
//   btn_right  in   level; rising edge moves the cursor one column right
//   btn_drop   in   level; rising edge drops a piece in the cursor column
//   panel      out  [1:0] per cell, [ROWS-1:0][COLS-1:0] unpacked
//                   00 empty, 01 red, 10 green
//   play       out  one-hot cursor column (bit COLS-1 = leftmost)
//   turn       out  0 = red to move, 1 = green to move
//   busy       out  high while a drop is being scanned/committed
//   col_full   out  one-cycle pulse when a drop hits a full column
//   game_over  out  board full; sticky until reset
// ---------------------------------------------------------------------------
module score4_game_ctrl #(
    parameter int ROWS        = 6,
    parameter int COLS        = 7,
    parameter int CURSOR_INIT = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_drop,
    output logic [1:0]      panel [ROWS-1:0][COLS-1:0],
    output logic [COLS-1:0] play,
    output logic            turn,
    output logic            busy,
    output logic            col_full,
    output logic            game_over
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CELLS = ROWS * COLS;
    localparam int CNT_W = $clog2(CELLS + 1);

    localparam logic [ROW_W-1:0] ROW_TOP    = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CELLS);
    localparam logic [COLS-1:0]  PLAY_INIT  = COLS'(1) << CURSOR_INIT;
    localparam logic [1:0]       CELL_EMPTY = 2'b00;
    localparam logic [1:0]       CELL_RED   = 2'b01;
    localparam logic [1:0]       CELL_GREEN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCAN   = 2'b01,
        ST_COMMIT = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    // Registers
    state_t           r_state;
    logic [2:0]       r_btn_q;
    logic [COLS-1:0]  r_play;
    logic             r_turn;
    logic             r_busy;
    logic             r_col_full;
    logic             r_game_over;
    logic [CNT_W-1:0] r_move_cnt;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_panel [ROWS-1:0][COLS-1:0];

    // Next-state / decode wires
    state_t           w_state_nxt;
    logic [2:0]       w_btn;
    logic [2:0]       w_edge;
    logic             w_edge_left;
    logic             w_edge_right;
    logic             w_edge_drop;
    logic [COLS-1:0]  w_play_nxt;
    logic             w_turn_nxt;
    logic             w_busy_nxt;
    logic             w_col_full_nxt;
    logic             w_game_over_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic             w_wr_en;
    logic [1:0]       w_wr_val;

    // Index of the set bit in a one-hot cursor vector.
    function automatic logic [COL_W-1:0] f_onehot_idx(input logic [COLS-1:0] p);
        logic [COL_W-1:0] idx;
        idx = {COL_W{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            if (p[i]) begin
                idx = COL_W'(i);
            end
        end
        return idx;
    endfunction

    // Cursor one column to the left (towards bit COLS-1).
    function automatic logic [COLS-1:0] f_cursor_left(input logic [COLS-1:0] p);
        logic [COLS-1:0] n;
        if (p[COLS-1]) begin
`ifdef WRAP_CURSOR_EN
            n = {{(COLS-1){1'b0}}, 1'b1};
`else
            n = p;
`endif
        end else begin
            n = {p[COLS-2:0], 1'b0};
        end
        return n;
    endfunction

    // Cursor one column to the right (towards bit 0).
    function automatic logic [COLS-1:0] f_cursor_right(input logic [COLS-1:0] p);
        logic [COLS-1:0] n;
        if (p[0]) begin
`ifdef WRAP_CURSOR_EN
            n = {1'b1, {(COLS-1){1'b0}}};
`else
            n = p;
`endif
        end else begin
            n = {1'b0, p[COLS-1:1]};
        end
        return n;
    endfunction

    assign w_btn        = {btn_drop, btn_right, btn_left};
    assign w_edge       = w_btn & ~r_btn_q;
    assign w_edge_left  = w_edge[0];
    assign w_edge_right = w_edge[1];
    assign w_edge_drop  = w_edge[2];

    // Next-state and datapath decode for the game sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_play_nxt      = r_play;
        w_turn_nxt      = r_turn;
        w_col_full_nxt  = 1'b0;
        w_game_over_nxt = r_game_over;
        w_cnt_nxt       = r_move_cnt;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_wr_en         = 1'b0;
        w_wr_val        = CELL_EMPTY;

        case (r_state)
            ST_IDLE: begin
                // A drop edge wins over any cursor edge in the same cycle.
                if (w_edge_drop) begin
                    w_col_nxt   = f_onehot_idx(r_play);
                    w_row_nxt   = {ROW_W{1'b0}};
                    w_state_nxt = ST_SCAN;
                end else if (w_edge_left && !w_edge_right) begin
                    w_play_nxt = f_cursor_left(r_play);
                end else if (w_edge_right && !w_edge_left) begin
                    w_play_nxt = f_cursor_right(r_play);
                end else begin
                    w_play_nxt = r_play;
                end
            end
            ST_SCAN: begin
                if (r_panel[r_row][r_col] == CELL_EMPTY) begin
                    w_wr_en     = 1'b1;
                    w_wr_val    = r_turn ? CELL_GREEN : CELL_RED;
                    w_state_nxt = ST_COMMIT;
                end else if (r_row == ROW_TOP) begin
                    // Column already full: reject without touching board/turn.
                    w_col_full_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_row_nxt = r_row + ROW_W'(1);
                end
            end
            ST_COMMIT: begin
                w_turn_nxt = ~r_turn;
                w_cnt_nxt  = r_move_cnt + CNT_W'(1);
                if (w_cnt_nxt == CNT_LAST) begin
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = ST_OVER;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OVER: begin
                // Terminal: only reset leaves this state.
                w_state_nxt = ST_OVER;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_SCAN) || (w_state_nxt == ST_COMMIT);
    end

    // State, control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_btn_q     <= 3'b000;
            r_play      <= PLAY_INIT;
            r_turn      <= 1'b0;
            r_busy      <= 1'b0;
            r_col_full  <= 1'b0;
            r_game_over <= 1'b0;
            r_move_cnt  <= {CNT_W{1'b0}};
            r_row       <= {ROW_W{1'b0}};
            r_col       <= {COL_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_btn_q     <= w_btn;
            r_play      <= w_play_nxt;
            r_turn      <= w_turn_nxt;
            r_busy      <= w_busy_nxt;
            r_col_full  <= w_col_full_nxt;
            r_game_over <= w_game_over_nxt;
            r_move_cnt  <= w_cnt_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
        end
    end

    // Board storage; a single cell write per drop, so the renderer never
    // sees an intermediate value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_panel[r][c] <= CELL_EMPTY;
                end
            end
        end else if (w_wr_en) begin
            r_panel[r_row][r_col] <= w_wr_val;
        end
    end

    assign panel     = r_panel;
    assign play      = r_play;
    assign turn      = r_turn;
    assign busy      = r_busy;
    assign col_full  = r_col_full;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_score4_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score4_game_ctrl
// Self-checking bench for score4_game_ctrl: a cursor vector table, hand
// sequences for drop latency / full column / discarded edges / mid-scan
// reset, and a randomized phase checked against a board-level model.
// ---------------------------------------------------------------------------
module tb_score4_game_ctrl;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    logic       clk;
    logic       rst;
    logic       btn_left;
    logic       btn_right;
    logic       btn_drop;
    logic [1:0] panel [ROWS-1:0][COLS-1:0];
    logic [COLS-1:0] play;
    logic       turn;
    logic       busy;
    logic       col_full;
    logic       game_over;

    score4_game_ctrl #(.ROWS(ROWS), .COLS(COLS), .CURSOR_INIT(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_drop  (btn_drop),
        .panel     (panel),
        .play      (play),
        .turn      (turn),
        .busy      (busy),
        .col_full  (col_full),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Board-level reference model
    int mdl_board [ROWS][COLS];
    int mdl_col;
    int mdl_turn;
    int mdl_cnt;
    int mdl_over;

    typedef struct {
        bit         l;
        bit         r;
        logic [6:0] exp_play;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack_dut();
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*2 +: 2] = panel[r][c];
        return v;
    endfunction

    function automatic logic [127:0] pack_mdl();
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*2 +: 2] = 2'(mdl_board[r][c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mdl_board[r][c] = 0;
        mdl_col  = 6;
        mdl_turn = 0;
        mdl_cnt  = 0;
        mdl_over = 0;
    endtask

    task automatic compare_all(input string nm);
        logic [COLS-1:0] ep;
        ep = COLS'(1) << mdl_col;
        chk({nm, "_panel"}, pack_dut(), pack_mdl());
        chk({nm, "_play"}, play, ep);
        chk({nm, "_turn"}, turn, mdl_turn[0]);
        chk({nm, "_over"}, game_over, mdl_over[0]);
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    task automatic reset_dut();
        btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic model_move(input bit l, input bit r);
        if (mdl_over == 0) begin
            if (l && !r) begin
                if (mdl_col == COLS-1) begin
`ifdef WRAP_CURSOR_EN
                    mdl_col = 0;
`endif
                end else mdl_col++;
            end else if (r && !l) begin
                if (mdl_col == 0) begin
`ifdef WRAP_CURSOR_EN
                    mdl_col = COLS-1;
`endif
                end else mdl_col--;
            end
        end
    endtask

    task automatic op_move(input bit l, input bit r);
        logic [COLS-1:0] ep;
        btn_left = l; btn_right = r;
        tick();
        btn_left = 1'b0; btn_right = 1'b0;
        model_move(l, r);
        ep = COLS'(1) << mdl_col;
        chk("move_play", play, ep);
        tick();
    endtask

    task automatic op_drop();
        int er;
        int lat;
        er = -1;
        for (int r = ROWS-1; r >= 0; r--)
            if (mdl_board[r][mdl_col] == 0) er = r;
        btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0;
        lat = 1;
        if (mdl_over != 0) begin
            chk("over_busy", busy, 1'b0);
            tick();
        end else begin
            while (busy === 1'b1 && lat < 60) begin
                tick();
                lat++;
            end
            if (er < 0) begin
                chk("full_lat", lat, 1 + ROWS);
                chk("col_full_pulse", col_full, 1'b1);
                tick();
                chk("col_full_clr", col_full, 1'b0);
            end else begin
                chk("drop_lat", lat, 3 + er);
                chk("drop_no_full", col_full, 1'b0);
                mdl_board[er][mdl_col] = (mdl_turn != 0) ? 2 : 1;
                mdl_turn ^= 1;
                mdl_cnt++;
                if (mdl_cnt == ROWS*COLS) mdl_over = 1;
            end
        end
        compare_all("drop");
    endtask

    task automatic goto_col(input int c);
        int guard;
        guard = 0;
        while (mdl_col < c && guard < 20) begin op_move(1'b1, 1'b0); guard++; end
        while (mdl_col > c && guard < 20) begin op_move(1'b0, 1'b1); guard++; end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
        rst = 1'b1;

        tbl[0] = '{l: 1'b0, r: 1'b1, exp_play: 7'b0100000};
        tbl[1] = '{l: 1'b0, r: 1'b1, exp_play: 7'b0010000};
        tbl[2] = '{l: 1'b0, r: 1'b1, exp_play: 7'b0001000};
        tbl[3] = '{l: 1'b1, r: 1'b0, exp_play: 7'b0010000};
        tbl[4] = '{l: 1'b1, r: 1'b1, exp_play: 7'b0010000};
        tbl[5] = '{l: 1'b1, r: 1'b0, exp_play: 7'b0100000};
        tbl[6] = '{l: 1'b1, r: 1'b0, exp_play: 7'b1000000};
`ifdef WRAP_CURSOR_EN
        tbl[7] = '{l: 1'b1, r: 1'b0, exp_play: 7'b0000001};
`else
        tbl[7] = '{l: 1'b1, r: 1'b0, exp_play: 7'b1000000};
`endif

        // Reset state
        reset_dut();
        chk("rst_play", play, 7'b1000000);
        chk("rst_turn", turn, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_col_full", col_full, 1'b0);
        chk("rst_over", game_over, 1'b0);
        chk("rst_panel", pack_dut(), 128'd0);
        chk("rst_cnt", dut.r_move_cnt, 6'd0);

        // Cursor vector table
        for (int i = 0; i < 8; i++) begin
            btn_left = tbl[i].l; btn_right = tbl[i].r;
            tick();
            btn_left = 1'b0; btn_right = 1'b0;
            chk($sformatf("tbl%0d_play", i), play, tbl[i].exp_play);
            chk($sformatf("tbl%0d_turn", i), turn, 1'b0);
            tick();
        end

        // First drop at col 6, cycle-accurate
        reset_dut();
        btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0;
        chk("d1_busy_n1", busy, 1'b1);
        chk("d1_cell_n1", panel[0][6], 2'b00);
        tick();
        chk("d1_cell_n2", panel[0][6], 2'b01);
        chk("d1_turn_n2", turn, 1'b0);
        chk("d1_busy_n2", busy, 1'b1);
        tick();
        chk("d1_turn_n3", turn, 1'b1);
        chk("d1_busy_n3", busy, 1'b0);
        mdl_board[0][6] = 1; mdl_turn = 1; mdl_cnt = 1;
        compare_all("d1");
        op_drop();
        chk("d2_cell", panel[1][6], 2'b10);

        // Fill column 3, then a rejected 7th drop
        reset_dut();
        goto_col(3);
        for (int i = 0; i < ROWS + 1; i++) op_drop();
        chk("full_cnt", dut.r_move_cnt, 6'd6);

        // Edges during a scan are discarded
        goto_col(4);
        btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0; btn_left = 1'b1;
        tick();
        btn_left = 1'b0; btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0;
        chk("ign_busy_n3", busy, 1'b0);
        chk("ign_play_n3", play, 7'b0010000);
        tick();
        chk("ign_busy_n4", busy, 1'b0);
        mdl_board[0][4] = 1; mdl_turn = 1; mdl_cnt = 7;
        compare_all("ign");

        // Reset while scanning row 2
        reset_dut();
        op_drop();
        op_drop();
        btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mid_panel", pack_dut(), 128'd0);
        chk("mid_busy_rst", busy, 1'b0);
        chk("mid_play", play, 7'b1000000);
        chk("mid_turn", turn, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        tick();
        tick();
        compare_all("mid");

        // Randomized play, then deterministic fill to game over
        reset_dut();
        for (int i = 0; i < 250 && mdl_over == 0; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 2)      op_move(1'b1, 1'b0);
            else if (op < 4) op_move(1'b0, 1'b1);
            else if (op < 5) op_move(1'b1, 1'b1);
            else             op_drop();
        end
        for (int c = 0; c < COLS; c++) begin
            if (mdl_over == 0) begin
                goto_col(c);
                while (mdl_board[ROWS-1][c] == 0 && mdl_over == 0) op_drop();
            end
        end
        chk("over_flag", game_over, 1'b1);
        op_move(1'b1, 1'b0);
        op_move(1'b0, 1'b1);
        op_drop();
        chk("over_cnt", dut.r_move_cnt, 6'd42);

        // Reset clears a finished game
        reset_dut();
        compare_all("post");
        chk("post_col_full", col_full, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
